// File: rtl/a1_ser_pkg.sv
// Shared types and defaults for the A1 byte serializer.
// Optional feature macro used by the design: ZERO_SKIP_EN (skip zero lanes).
package a1_ser_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 16;
  localparam int NUM_LANES = 8;

  typedef logic [2:0] lane_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // One input group at the default lane width; index 0 is lane 1.
  typedef logic [NUM_LANES-1:0][WIDTH_DEF-1:0] group_t;

endpackage

// File: rtl/a1_lane_pick.sv
// Next-lane finder for the zero-skip build (ZERO_SKIP_EN).
// Given the mask of nonzero lanes and the current index, returns the lowest
// eligible lane (above idx_i, or at idx_i when incl_i is set), whether one
// exists, and whether no further nonzero lane lies beyond it.
module a1_lane_pick
  import a1_ser_pkg::*;
(
  input  logic [NUM_LANES-1:0] mask_i,
  input  lane_idx_t            idx_i,
  input  logic                 incl_i,
  output lane_idx_t            next_idx_o,
  output logic                 found_o,
  output logic                 is_last_o
);

  logic [NUM_LANES-1:0] cand;
  logic [NUM_LANES-1:0] above;

  // Lanes that are nonzero and not yet passed.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cand[i] = mask_i[i] && ((i > int'(idx_i)) || (incl_i && (i == int'(idx_i))));
    end
  end

  // Lowest candidate wins; the loop runs downward so the last hit is lowest.
  always_comb begin
    next_idx_o = lane_idx_t'(NUM_LANES - 1);
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (cand[i]) next_idx_o = lane_idx_t'(i);
    end
  end

  // Lanes strictly above the chosen one, used to decide the last beat.
  always_comb begin
    above = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      above[i] = (i > int'(next_idx_o));
    end
  end

  assign found_o   = |cand;
  assign is_last_o = ~|(mask_i & above);

endmodule

// File: rtl/a1_byte_serializer.sv
// A1 byte serializer: takes an 8-lane group per accepted beat and emits it one
// byte per cycle with a two-group (CUR/NXT) buffer so consecutive groups flow
// without a bubble. Counts fully emitted groups.
// Optional feature: define ZERO_SKIP_EN to drop zero lanes from the stream.
//
// Handshakes: a transfer happens on a rising edge where valid && ready. The
// producer keeps data and valid stable until that edge. InReady is a register
// (NXT not full); SerValid/SerOut/SerLane/SerLast are registers held while
// SerValid && !SerReady. Neither ready depends combinationally on the other side.
module a1_byte_serializer
  import a1_ser_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] A1Out1,
  input  logic [WIDTH-1:0] A1Out2,
  input  logic [WIDTH-1:0] A1Out3,
  input  logic [WIDTH-1:0] A1Out4,
  input  logic [WIDTH-1:0] A1Out5,
  input  logic [WIDTH-1:0] A1Out6,
  input  logic [WIDTH-1:0] A1Out7,
  input  logic [WIDTH-1:0] A1Out8,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] SerOut,
  output logic [2:0]       SerLane,
  output logic             SerValid,
  input  logic             SerReady,
  output logic             SerLast,
  output logic [CNT_W-1:0] GroupCnt,
  output logic             DbgState
);

  typedef logic [NUM_LANES-1:0][WIDTH-1:0] grp_t;

  ser_state_e       state_q, state_d;
  grp_t             cur_q, cur_d;
  grp_t             nxt_q, nxt_d;
  logic             nxt_full_q, nxt_full_d;
  lane_idx_t        lane_q, lane_d;
  logic [WIDTH-1:0] ser_out_q, ser_out_d;
  logic             ser_last_q, ser_last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  grp_t      in_grp;
  grp_t      load_grp;
  lane_idx_t load_lane;
  logic      load_last;
  lane_idx_t adv_lane;
  logic      adv_last;

  logic hs;
  logic last_hs;
  logic accept;
  logic cur_from_nxt;
  logic cur_from_in;
  logic nxt_load;

  assign in_grp = {A1Out8, A1Out7, A1Out6, A1Out5, A1Out4, A1Out3, A1Out2, A1Out1};

  assign hs      = (state_q == SHIFT) && SerReady;
  assign last_hs = hs && ser_last_q;
  assign accept  = InValid && !nxt_full_q;

  // CUR refills from NXT when the last beat leaves with NXT occupied; an
  // incoming group goes straight to CUR when CUR is empty or just finishing.
  assign cur_from_nxt = last_hs && nxt_full_q;
  assign cur_from_in  = accept && ((state_q == IDLE) || last_hs);
  assign nxt_load     = accept && !cur_from_in;
  assign load_grp     = cur_from_nxt ? nxt_q : in_grp;

`ifdef ZERO_SKIP_EN
  logic [NUM_LANES-1:0] cur_mask_q, cur_mask_d;
  logic [NUM_LANES-1:0] load_mask;
  lane_idx_t            load_pick_idx;
  logic                 load_found;
  logic                 load_pick_last;
  lane_idx_t            adv_pick_idx;
  logic                 adv_found;

  // Nonzero-lane mask of the group about to enter CUR.
  always_comb begin
    load_mask = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      load_mask[i] = |load_grp[i];
    end
  end

  a1_lane_pick u_load_pick (
    .mask_i     (load_mask),
    .idx_i      (3'd0),
    .incl_i     (1'b1),
    .next_idx_o (load_pick_idx),
    .found_o    (load_found),
    .is_last_o  (load_pick_last)
  );

  a1_lane_pick u_adv_pick (
    .mask_i     (cur_mask_q),
    .idx_i      (lane_q),
    .incl_i     (1'b0),
    .next_idx_o (adv_pick_idx),
    .found_o    (adv_found),
    .is_last_o  (adv_last)
  );

  // An all-zero group still emits one beat: lane 8 (byte is 0) marked last.
  assign load_lane = load_found ? load_pick_idx : 3'd7;
  assign load_last = load_found ? load_pick_last : 1'b1;
  assign adv_lane  = adv_found ? adv_pick_idx : lane_q;
`else
  assign load_lane = 3'd0;
  assign load_last = 1'b0;
  assign adv_lane  = lane_q + 3'd1;
  assign adv_last  = (adv_lane == 3'd7);
`endif

  // Next-state, buffer and output-register logic.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    nxt_full_d = nxt_full_q;
    lane_d     = lane_q;
    ser_out_d  = ser_out_q;
    ser_last_d = ser_last_q;
    cnt_d      = cnt_q;
`ifdef ZERO_SKIP_EN
    cur_mask_d = cur_mask_q;
`endif

    if (cur_from_nxt || cur_from_in) begin
      state_d    = SHIFT;
      cur_d      = load_grp;
      lane_d     = load_lane;
      ser_out_d  = load_grp[load_lane];
      ser_last_d = load_last;
`ifdef ZERO_SKIP_EN
      cur_mask_d = load_mask;
`endif
    end else if (last_hs) begin
      state_d = IDLE;
    end else if (hs) begin
      lane_d     = adv_lane;
      ser_out_d  = cur_q[adv_lane];
      ser_last_d = adv_last;
    end

    if (cur_from_nxt) begin
      nxt_full_d = 1'b0;
    end else if (nxt_load) begin
      nxt_full_d = 1'b1;
      nxt_d      = in_grp;
    end

    if (last_hs) cnt_d = cnt_q + 1'b1;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      nxt_q      <= '0;
      nxt_full_q <= 1'b0;
      lane_q     <= '0;
      ser_out_q  <= '0;
      ser_last_q <= 1'b0;
      cnt_q      <= '0;
`ifdef ZERO_SKIP_EN
      cur_mask_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      nxt_full_q <= nxt_full_d;
      lane_q     <= lane_d;
      ser_out_q  <= ser_out_d;
      ser_last_q <= ser_last_d;
      cnt_q      <= cnt_d;
`ifdef ZERO_SKIP_EN
      cur_mask_q <= cur_mask_d;
`endif
    end
  end

  assign InReady  = !nxt_full_q;
  assign SerValid = (state_q == SHIFT);
  assign SerOut   = ser_out_q;
  assign SerLane  = lane_q;
  assign SerLast  = ser_last_q;
  assign GroupCnt = cnt_q;
  assign DbgState = state_q;

endmodule

// File: tb/tb_a1_byte_serializer.sv
// Testbench for a1_byte_serializer (default build and ZERO_SKIP_EN build).
module tb_a1_byte_serializer;
  import a1_ser_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int BW    = WIDTH + 3 + 1;

  logic             Clk;
  logic             Rst;
  logic [WIDTH-1:0] A1Out1, A1Out2, A1Out3, A1Out4, A1Out5, A1Out6, A1Out7, A1Out8;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] SerOut;
  logic [2:0]       SerLane;
  logic             SerValid;
  logic             SerReady;
  logic             SerLast;
  logic [CNT_W-1:0] GroupCnt;
  logic             DbgState;

  a1_byte_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst),
    .A1Out1(A1Out1), .A1Out2(A1Out2), .A1Out3(A1Out3), .A1Out4(A1Out4),
    .A1Out5(A1Out5), .A1Out6(A1Out6), .A1Out7(A1Out7), .A1Out8(A1Out8),
    .InValid(InValid), .InReady(InReady),
    .SerOut(SerOut), .SerLane(SerLane), .SerValid(SerValid), .SerReady(SerReady),
    .SerLast(SerLast), .GroupCnt(GroupCnt), .DbgState(DbgState)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  int checks = 0;
  int errors = 0;

  logic [BW-1:0]    exp_q[$];
  logic [BW-1:0]    beat_log[$];
  int               beat_cyc[$];
  logic [CNT_W-1:0] model_cnt = '0;
  int               ready_low_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset(input int n);
    Rst = 1'b1;
    repeat (n) @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask

  // Expected beats for one group; index 0 of g is lane 1.
  function automatic void push_group(input logic [63:0] g);
`ifdef ZERO_SKIP_EN
    int hi = -1;
    for (int l = 0; l < 8; l++) if (g[8*l +: 8] != 8'h00) hi = l;
    if (hi < 0) exp_q.push_back({8'h00, 3'd7, 1'b1});
    else
      for (int l = 0; l < 8; l++)
        if (g[8*l +: 8] != 8'h00) exp_q.push_back({g[8*l +: 8], 3'(l), (l == hi)});
`else
    for (int l = 0; l < 8; l++) exp_q.push_back({g[8*l +: 8], 3'(l), (l == 7)});
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_group(input logic [63:0] g, output int acc_c);
    int t = 0;
    logic accepted = 1'b0;
    acc_c = -1;
    {A1Out8, A1Out7, A1Out6, A1Out5, A1Out4, A1Out3, A1Out2, A1Out1} = g;
    InValid = 1'b1;
    while (!accepted && t < 100) begin
      @(negedge Clk);
      if (InReady) begin
        push_group(g);
        acc_c = cyc;
        accepted = 1'b1;
      end else begin
        ready_low_cnt++;
      end
      t++;
      @(posedge Clk);
      #1;
    end
    if (!accepted) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_in();
    InValid = 1'b0;
    {A1Out8, A1Out7, A1Out6, A1Out5, A1Out4, A1Out3, A1Out2, A1Out1} = '0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge Clk);
      t++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic clear_logs();
    beat_log.delete();
    beat_cyc.delete();
  endtask

  // Wait (bounded) until the given lane is presented; optionally require NXT full.
  task automatic wait_lane(input logic [2:0] lane, input logic need_full, output logic found);
    int t = 0;
    found = 1'b0;
    while (!found && t < 60) begin
      @(posedge Clk);
      #1;
      if (SerValid && SerLane == lane && (!need_full || !InReady)) found = 1'b1;
      t++;
    end
    if (!found) check("wait_lane_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic          prev_rst   = 1'b0;
  logic          prev_stall = 1'b0;
  logic [BW-1:0] held_v;

  initial forever begin
    @(negedge Clk);
    if (Rst) begin
      exp_q.delete();
      model_cnt  = '0;
      prev_rst   = 1'b1;
      prev_stall = 1'b0;
    end else begin
      if (prev_rst) begin
        check("rst_ser_valid", SerValid, 32'd0);
        check("rst_in_ready", InReady, 32'd1);
        check("rst_ser_out", SerOut, 32'd0);
        check("rst_ser_lane", SerLane, 32'd0);
        check("rst_ser_last", SerLast, 32'd0);
      end
      prev_rst = 1'b0;
      check("group_cnt", GroupCnt, model_cnt);
      if (prev_stall) check("stall_hold", {SerValid, SerOut, SerLane, SerLast}, {1'b1, held_v});
      if (SerValid && SerReady) begin
        if (exp_q.size() == 0) check("unexpected_beat", {SerOut, SerLane, SerLast}, 32'hFFFF_FFFF);
        else check("beat", {SerOut, SerLane, SerLast}, exp_q.pop_front());
        beat_log.push_back({SerOut, SerLane, SerLast});
        beat_cyc.push_back(cyc);
        if (SerLast) model_cnt = model_cnt + 1'b1;
      end
      prev_stall = SerValid && !SerReady;
      held_v     = {SerOut, SerLane, SerLast};
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int acc;
    logic ok;
    Rst      = 1'b1;
    SerReady = 1'b1;
    idle_in();

    // 1: reset held two cycles
    do_reset(2);
    repeat (2) @(posedge Clk);
    #1;
    check("t1_valid_idle", SerValid, 32'd0);
    check("t1_cnt", GroupCnt, 32'd0);

    // 2: one group, latency and lane order
    clear_logs();
    send_group(64'h8877_6655_4433_2211, acc);
    idle_in();
    drain();
    check("t2_beats", beat_log.size(), 32'd8);
    if (beat_log.size() >= 8) begin
      check("t2_first", beat_log[0], {8'h11, 3'd0, 1'b0});
      check("t2_mid", beat_log[4], {8'h55, 3'd4, 1'b0});
      check("t2_last", beat_log[7], {8'h88, 3'd7, 1'b1});
      check("t2_latency", beat_cyc[0], acc + 1);
      check("t2_span", beat_cyc[7], acc + 8);
    end
    check("t2_cnt", GroupCnt, 32'd1);

    // 3: three back-to-back groups, InValid held
    clear_logs();
    ready_low_cnt = 0;
    send_group(64'h1817_1615_1413_1211, acc);
    send_group(64'h2827_2625_2423_2221, acc);
    send_group(64'h3837_3635_3433_3231, acc);
    idle_in();
    drain();
    check("t3_beats", beat_log.size(), 32'd24);
    if (beat_log.size() >= 24) begin
      check("t3_no_gap", beat_cyc[23] - beat_cyc[0], 32'd23);
      check("t3_b8", beat_log[8], {8'h21, 3'd0, 1'b0});
      check("t3_b23", beat_log[23], {8'h38, 3'd7, 1'b1});
    end
    check("t3_inready_low", ready_low_cnt, 32'd7);
    check("t3_cnt", GroupCnt, 32'd4);

    // 4: backpressure for 5 cycles on the third beat
    clear_logs();
    fork
      begin
        send_group(64'h4847_4645_4443_4241, acc);
        idle_in();
      end
      begin
        wait_lane(3'd2, 1'b0, ok);
        SerReady = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        SerReady = 1'b1;
      end
    join
    drain();
    check("t4_beats", beat_log.size(), 32'd8);
    if (beat_log.size() >= 8) begin
      check("t4_b2", beat_log[2], {8'h43, 3'd2, 1'b0});
      check("t4_b3", beat_log[3], {8'h44, 3'd3, 1'b0});
      check("t4_span", beat_cyc[7] - beat_cyc[0], 32'd12);
    end
    check("t4_cnt", GroupCnt, 32'd5);

    // 5: reset at beat 4 with NXT full
    send_group(64'h5857_5655_5453_5251, acc);
    send_group(64'h6867_6665_6463_6261, acc);
    idle_in();
    wait_lane(3'd3, 1'b1, ok);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    @(negedge Clk);
    check("t5_valid", SerValid, 32'd0);
    check("t5_cnt", GroupCnt, 32'd0);
    @(posedge Clk);
    #1;
    clear_logs();
    send_group(64'h7877_7675_7473_7271, acc);
    idle_in();
    drain();
    check("t5_beats", beat_log.size(), 32'd8);
    if (beat_log.size() >= 1) check("t5_first", beat_log[0], {8'h71, 3'd0, 1'b0});
    check("t5_cnt_after", GroupCnt, 32'd1);

    // 6: zero lanes
    clear_logs();
    send_group(64'h0000_0009_0000_0500, acc);
    send_group(64'h0, acc);
    idle_in();
    drain();
`ifdef ZERO_SKIP_EN
    check("t6_beats", beat_log.size(), 32'd3);
    if (beat_log.size() >= 3) begin
      check("t6_b0", beat_log[0], {8'h05, 3'd1, 1'b0});
      check("t6_b1", beat_log[1], {8'h09, 3'd4, 1'b1});
      check("t6_zero_grp", beat_log[2], {8'h00, 3'd7, 1'b1});
    end
`else
    check("t6_beats", beat_log.size(), 32'd16);
    if (beat_log.size() >= 16) begin
      check("t6_b0", beat_log[0], {8'h00, 3'd0, 1'b0});
      check("t6_b1", beat_log[1], {8'h05, 3'd1, 1'b0});
      check("t6_b4", beat_log[4], {8'h09, 3'd4, 1'b0});
      check("t6_b7", beat_log[7], {8'h00, 3'd7, 1'b1});
      check("t6_zero_last", beat_log[15], {8'h00, 3'd7, 1'b1});
    end
`endif
    check("t6_cnt", GroupCnt, 32'd3);

    // 7: GroupCnt wraps after 16 groups with CNT_W=4
    do_reset(1);
    clear_logs();
    for (int i = 0; i < 16; i++) send_group({8{8'(i + 1)}}, acc);
    idle_in();
    drain();
    check("t7_beats", beat_log.size(), 32'd128);
    check("t7_wrap", GroupCnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
